// File: rtl/bram_rd_sched_pkg.sv
// Shared constants, index widths and the LVT entry type for the BRAM read scheduler.
package bram_rd_sched_pkg;

    localparam int unsigned DEF_NB_WRAGENT = 2;
    localparam int unsigned DEF_NB_RDAGENT = 2;
    localparam int unsigned DEF_ADDR_WIDTH = 3;
    localparam int unsigned DEF_DATA_WIDTH = 8;

    // $clog2 returns 0 for a single element; an index still needs one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned BANK_W = clog2_min1(DEF_NB_WRAGENT);
    localparam int unsigned AGT_W  = clog2_min1(DEF_NB_RDAGENT);

    // One LVT entry: index of the bank holding the live copy of an address.
    typedef logic [BANK_W-1:0] lvt_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; the search starts at ptr and wraps once.
module rr_arbiter #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx
);

    logic found;

    // Two passes: first requesters at or above ptr, then the wrapped ones below it.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = W'(i);
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            if (!found && req[i]) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/bram_rd_sched.sv
// Read-side scheduler for a per-write-agent BRAM bank array. A live value table
// tracks which bank last wrote each address; reads are routed to that bank and
// arbitrated round-robin per bank. Writes pass straight through to the banks.
module bram_rd_sched
    import bram_rd_sched_pkg::*;
#(
    parameter int unsigned NB_WRAGENT = DEF_NB_WRAGENT,
    parameter int unsigned NB_RDAGENT = DEF_NB_RDAGENT,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned RAM_DEPTH  = 2**ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NB_WRAGENT-1:0]            wren,
    input  logic [ADDR_WIDTH*NB_WRAGENT-1:0] wraddr,
    input  logic [DATA_WIDTH*NB_WRAGENT-1:0] wrdata,
    output logic [NB_WRAGENT-1:0]            bank_wren,
    output logic [ADDR_WIDTH*NB_WRAGENT-1:0] bank_wraddr,
    output logic [DATA_WIDTH*NB_WRAGENT-1:0] bank_wrdata,
    input  logic [NB_RDAGENT-1:0]            rd_valid,
    output logic [NB_RDAGENT-1:0]            rd_ready,
    input  logic [ADDR_WIDTH*NB_RDAGENT-1:0] rd_addr,
    output logic [NB_RDAGENT-1:0]            rd_rvalid,
    output logic [DATA_WIDTH*NB_RDAGENT-1:0] rd_rdata,
    output logic [NB_WRAGENT-1:0]            bank_rden,
    output logic [ADDR_WIDTH*NB_WRAGENT-1:0] bank_rdaddr,
    input  logic [DATA_WIDTH*NB_WRAGENT-1:0] bank_rddata
);

    localparam int unsigned BANK_IW = clog2_min1(NB_WRAGENT);
    localparam int unsigned AGT_IW  = clog2_min1(NB_RDAGENT);

    logic [BANK_IW-1:0]    lvt_q    [RAM_DEPTH];
    logic [BANK_IW-1:0]    owner    [NB_RDAGENT];
    logic [NB_RDAGENT-1:0] hazard;
    logic [NB_RDAGENT-1:0] bank_req [NB_WRAGENT];
    logic [NB_RDAGENT-1:0] bank_gnt [NB_WRAGENT];
    logic [AGT_IW-1:0]     gnt_idx  [NB_WRAGENT];
    logic [AGT_IW-1:0]     ptr_q    [NB_WRAGENT];
    logic [AGT_IW-1:0]     ptr_d    [NB_WRAGENT];
    logic [NB_RDAGENT-1:0] pend_q;
    logic [BANK_IW-1:0]    sel_q    [NB_RDAGENT];
    logic [NB_RDAGENT-1:0] rvalid_q;
    logic [DATA_WIDTH*NB_RDAGENT-1:0] rdata_q;
    logic [DATA_WIDTH*NB_RDAGENT-1:0] rdata_d;

    assign bank_wren   = wren;
    assign bank_wraddr = wraddr;
    assign bank_wrdata = wrdata;

    // LVT update; later loop iterations override, so the highest writing agent wins.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int a = 0; a < int'(RAM_DEPTH); a++) begin
                lvt_q[a] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NB_WRAGENT); i++) begin
                if (wren[i]) begin
                    lvt_q[wraddr[i*ADDR_WIDTH +: ADDR_WIDTH]] <= BANK_IW'(i);
                end
            end
        end
    end

    // Owner lookup and same-cycle write hazard per read agent.
    always_comb begin
        for (int j = 0; j < int'(NB_RDAGENT); j++) begin
            owner[j]  = lvt_q[rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH]];
            hazard[j] = 1'b0;
            for (int i = 0; i < int'(NB_WRAGENT); i++) begin
                if (wren[i] &&
                    (wraddr[i*ADDR_WIDTH +: ADDR_WIDTH] == rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    hazard[j] = 1'b1;
                end
            end
        end
    end

    // Candidate set per bank: valid, owned by this bank, not stalled by a hazard.
    always_comb begin
        for (int b = 0; b < int'(NB_WRAGENT); b++) begin
            for (int j = 0; j < int'(NB_RDAGENT); j++) begin
                bank_req[b][j] = rd_valid[j] & ~hazard[j] & (owner[j] == BANK_IW'(b));
            end
        end
    end

    for (genvar b = 0; b < int'(NB_WRAGENT); b++) begin : g_arb
        rr_arbiter #(
            .N(NB_RDAGENT),
            .W(AGT_IW)
        ) u_arb (
            .req      (bank_req[b]),
            .ptr      (ptr_q[b]),
            .grant    (bank_gnt[b]),
            .grant_idx(gnt_idx[b])
        );
    end

    // Ready, bank read enables and addresses from the per-bank grants.
    always_comb begin
        rd_ready    = '0;
        bank_rden   = '0;
        bank_rdaddr = '0;
        for (int b = 0; b < int'(NB_WRAGENT); b++) begin
            bank_rden[b] = |bank_gnt[b];
            rd_ready     = rd_ready | bank_gnt[b];
            for (int j = 0; j < int'(NB_RDAGENT); j++) begin
                if (bank_gnt[b][j]) begin
                    bank_rdaddr[b*ADDR_WIDTH +: ADDR_WIDTH] = rd_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                end
            end
        end
    end

    // Next RR pointer: one past the grantee, wrapping at NB_RDAGENT.
    always_comb begin
        for (int b = 0; b < int'(NB_WRAGENT); b++) begin
            ptr_d[b] = ptr_q[b];
            if (|bank_gnt[b]) begin
                ptr_d[b] = (gnt_idx[b] == AGT_IW'(NB_RDAGENT - 1)) ? '0 : gnt_idx[b] + 1'b1;
            end
        end
    end

    // RR pointer registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int b = 0; b < int'(NB_WRAGENT); b++) begin
                ptr_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < int'(NB_WRAGENT); b++) begin
                ptr_q[b] <= ptr_d[b];
            end
        end
    end

    // Remember which bank each accepted read went to; its data returns next cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pend_q <= '0;
            for (int j = 0; j < int'(NB_RDAGENT); j++) begin
                sel_q[j] <= '0;
            end
        end else begin
            pend_q <= rd_ready;
            for (int j = 0; j < int'(NB_RDAGENT); j++) begin
                if (rd_ready[j]) begin
                    sel_q[j] <= owner[j];
                end
            end
        end
    end

    // Steer each pending agent's bank data; hold the last value otherwise.
    always_comb begin
        rdata_d = rdata_q;
        for (int j = 0; j < int'(NB_RDAGENT); j++) begin
            if (pend_q[j]) begin
                for (int b = 0; b < int'(NB_WRAGENT); b++) begin
                    if (sel_q[j] == BANK_IW'(b)) begin
                        rdata_d[j*DATA_WIDTH +: DATA_WIDTH] = bank_rddata[b*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    // Registered response stage.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= pend_q;
            rdata_q  <= rdata_d;
        end
    end

    assign rd_rvalid = rvalid_q;
    assign rd_rdata  = rdata_q;

endmodule

// File: tb/tb_bram_rd_sched.sv
// Directed bench for bram_rd_sched with a behavioural model of the BRAM banks.
module tb_bram_rd_sched;

    localparam int NW = 2;
    localparam int NR = 2;
    localparam int AW = 3;
    localparam int DW = 8;

    logic              aclk;
    logic              aresetn;
    logic [NW-1:0]     wren;
    logic [AW*NW-1:0]  wraddr;
    logic [DW*NW-1:0]  wrdata;
    logic [NW-1:0]     bank_wren;
    logic [AW*NW-1:0]  bank_wraddr;
    logic [DW*NW-1:0]  bank_wrdata;
    logic [NR-1:0]     rd_valid;
    logic [NR-1:0]     rd_ready;
    logic [AW*NR-1:0]  rd_addr;
    logic [NR-1:0]     rd_rvalid;
    logic [DW*NR-1:0]  rd_rdata;
    logic [NW-1:0]     bank_rden;
    logic [AW*NW-1:0]  bank_rdaddr;
    logic [DW*NW-1:0]  bank_rddata;

    int n_cmp;
    int n_fail;

    bram_rd_sched #(
        .NB_WRAGENT(NW),
        .NB_RDAGENT(NR),
        .ADDR_WIDTH(AW),
        .RAM_DEPTH (2**AW),
        .DATA_WIDTH(DW)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .wren       (wren),
        .wraddr     (wraddr),
        .wrdata     (wrdata),
        .bank_wren  (bank_wren),
        .bank_wraddr(bank_wraddr),
        .bank_wrdata(bank_wrdata),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .rd_rvalid  (rd_rvalid),
        .rd_rdata   (rd_rdata),
        .bank_rden  (bank_rden),
        .bank_rdaddr(bank_rdaddr),
        .bank_rddata(bank_rddata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Bank model: one memory per write agent, registered read port.
    logic [DW-1:0] mem [NW][2**AW];
    logic [DW-1:0] rdq [NW];

    always @(posedge aclk) begin
        for (int b = 0; b < NW; b++) begin
            if (bank_wren[b]) mem[b][bank_wraddr[b*AW +: AW]] <= bank_wrdata[b*DW +: DW];
            if (bank_rden[b]) rdq[b] <= mem[b][bank_rdaddr[b*AW +: AW]];
        end
    end
    assign bank_rddata = {rdq[1], rdq[0]};

    typedef struct {
        logic [1:0] wren;
        logic [2:0] wa0;
        logic [2:0] wa1;
        logic [7:0] wd0;
        logic [7:0] wd1;
        logic [1:0] rv;
        logic [2:0] ra0;
        logic [2:0] ra1;
        logic [1:0] e_ready;
        logic [1:0] e_rden;
        logic [5:0] e_rdaddr;
        logic [1:0] e_rvalid;
        logic [7:0] e_rd0;
        logic [7:0] e_rd1;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic [1:0] we, input logic [2:0] wa0, input logic [2:0] wa1,
                         input logic [7:0] wd0, input logic [7:0] wd1,
                         input logic [1:0] rv, input logic [2:0] ra0, input logic [2:0] ra1);
        wren     = we;
        wraddr   = {wa1, wa0};
        wrdata   = {wd1, wd0};
        rd_valid = rv;
        rd_addr  = {ra1, ra0};
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        aresetn = 1'b0;
        drive(2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 3'd0, 3'd0);

        // wren wa0 wa1 wd0 wd1 | rv ra0 ra1 | ready rden rdaddr rvalid rd0 rd1
        vecs[0]  = '{2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 3'd0, 3'd0,
                     2'b00, 2'b00, 6'o00, 2'b00, 8'h00, 8'h00};
        vecs[1]  = '{2'b10, 3'd0, 3'd3, 8'h00, 8'hA5, 2'b00, 3'd0, 3'd0,
                     2'b00, 2'b00, 6'o00, 2'b00, 8'h00, 8'h00};
        vecs[2]  = '{2'b11, 3'd5, 3'd5, 8'h11, 8'h22, 2'b00, 3'd0, 3'd0,
                     2'b00, 2'b00, 6'o00, 2'b00, 8'h00, 8'h00};
        vecs[3]  = '{2'b01, 3'd1, 3'd0, 8'h31, 8'h00, 2'b00, 3'd0, 3'd0,
                     2'b00, 2'b00, 6'o00, 2'b00, 8'h00, 8'h00};
        vecs[4]  = '{2'b01, 3'd2, 3'd0, 8'h42, 8'h00, 2'b00, 3'd0, 3'd0,
                     2'b00, 2'b00, 6'o00, 2'b00, 8'h00, 8'h00};
        vecs[5]  = '{2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b01, 3'd3, 3'd0,
                     2'b01, 2'b10, 6'o30, 2'b00, 8'h00, 8'h00};
        vecs[6]  = '{2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b01, 3'd5, 3'd0,
                     2'b01, 2'b10, 6'o50, 2'b00, 8'h00, 8'h00};
        vecs[7]  = '{2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 3'd0, 3'd0,
                     2'b00, 2'b00, 6'o00, 2'b01, 8'hA5, 8'h00};
        vecs[8]  = '{2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b11, 3'd1, 3'd2,
                     2'b01, 2'b01, 6'o01, 2'b01, 8'h22, 8'h00};
        vecs[9]  = '{2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b11, 3'd1, 3'd2,
                     2'b10, 2'b01, 6'o02, 2'b00, 8'h00, 8'h00};
        vecs[10] = '{2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b11, 3'd1, 3'd2,
                     2'b01, 2'b01, 6'o01, 2'b01, 8'h31, 8'h00};
        vecs[11] = '{2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b11, 3'd1, 3'd2,
                     2'b10, 2'b01, 6'o02, 2'b10, 8'h00, 8'h42};
        vecs[12] = '{2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 3'd0, 3'd0,
                     2'b00, 2'b00, 6'o00, 2'b01, 8'h31, 8'h00};
        vecs[13] = '{2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b11, 3'd1, 3'd3,
                     2'b11, 2'b11, 6'o31, 2'b10, 8'h00, 8'h42};
        vecs[14] = '{2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 3'd0, 3'd0,
                     2'b00, 2'b00, 6'o00, 2'b00, 8'h00, 8'h00};
        vecs[15] = '{2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 3'd0, 3'd0,
                     2'b00, 2'b00, 6'o00, 2'b11, 8'h31, 8'hA5};

        repeat (2) @(posedge aclk);
        #1;
        chk("reset rvalid", 32'(rd_rvalid), 32'h0);
        chk("reset rdata", 32'(rd_rdata), 32'h0);
        aresetn = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].wren, vecs[i].wa0, vecs[i].wa1, vecs[i].wd0, vecs[i].wd1,
                  vecs[i].rv, vecs[i].ra0, vecs[i].ra1);
            #2;
            chk($sformatf("row%0d rd_ready", i), 32'(rd_ready), 32'(vecs[i].e_ready));
            chk($sformatf("row%0d bank_rden", i), 32'(bank_rden), 32'(vecs[i].e_rden));
            chk($sformatf("row%0d bank_rdaddr", i), 32'(bank_rdaddr), 32'(vecs[i].e_rdaddr));
            chk($sformatf("row%0d rd_rvalid", i), 32'(rd_rvalid), 32'(vecs[i].e_rvalid));
            if (vecs[i].e_rvalid[0])
                chk($sformatf("row%0d rd_rdata0", i), 32'(rd_rdata[7:0]), 32'(vecs[i].e_rd0));
            if (vecs[i].e_rvalid[1])
                chk($sformatf("row%0d rd_rdata1", i), 32'(rd_rdata[15:8]), 32'(vecs[i].e_rd1));
            tick();
        end

        // Hazard: read of addr 4 collides with agent1's write of addr 4.
        drive(2'b10, 3'd0, 3'd4, 8'h00, 8'h7E, 2'b01, 3'd4, 3'd0);
        #2;
        chk("hazard stall ready", 32'(rd_ready), 32'h0);
        chk("hazard stall rden", 32'(bank_rden), 32'h0);
        tick();
        drive(2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b01, 3'd4, 3'd0);
        #2;
        chk("hazard retry ready", 32'(rd_ready), 32'h1);
        chk("hazard retry rden", 32'(bank_rden), 32'h2);
        chk("hazard retry rdaddr", 32'(bank_rdaddr), 32'o40);
        tick();
        drive(2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 3'd0, 3'd0);
        #2;
        chk("hazard rvalid early", 32'(rd_rvalid), 32'h0);
        tick();
        #2;
        chk("hazard rvalid", 32'(rd_rvalid), 32'h1);
        chk("hazard rdata", 32'(rd_rdata[7:0]), 32'h7E);
        tick();

        // Reset in flight: both agents write addr 6, read goes to bank 1, reset drops it.
        drive(2'b11, 3'd6, 3'd6, 8'h5C, 8'h6D, 2'b00, 3'd0, 3'd0);
        #2;
        chk("wr passthrough en", 32'(bank_wren), 32'h3);
        chk("wr passthrough addr", 32'(bank_wraddr), 32'o66);
        chk("wr passthrough data", 32'(bank_wrdata), 32'h6D5C);
        tick();
        drive(2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b01, 3'd6, 3'd0);
        #2;
        chk("pre-reset ready", 32'(rd_ready), 32'h1);
        chk("pre-reset rden", 32'(bank_rden), 32'h2);
        tick();
        drive(2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 3'd0, 3'd0);
        aresetn = 1'b0;
        #2;
        chk("in-reset rvalid a", 32'(rd_rvalid), 32'h0);
        tick();
        chk("in-reset rvalid b", 32'(rd_rvalid), 32'h0);
        tick();
        aresetn = 1'b1;
        drive(2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b01, 3'd6, 3'd0);
        #2;
        chk("post-reset ready", 32'(rd_ready), 32'h1);
        chk("post-reset rden", 32'(bank_rden), 32'h1);
        chk("post-reset rdaddr", 32'(bank_rdaddr), 32'o06);
        tick();
        drive(2'b00, 3'd0, 3'd0, 8'h00, 8'h00, 2'b00, 3'd0, 3'd0);
        #2;
        chk("post-reset rvalid early", 32'(rd_rvalid), 32'h0);
        tick();
        #2;
        chk("post-reset rvalid", 32'(rd_rvalid), 32'h1);
        chk("post-reset rdata", 32'(rd_rdata[7:0]), 32'h5C);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
